rv32i_wb_arbiter: RTL and testbench

//   Write-side counterpart of the integer register file: collects results from NUM_SRC

---
 rtl/rv32i_wb_arbiter.sv | 108 ++++++++++
 tb/tb_rv32i_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rv32i_wb_arbiter.sv
// Writeback arbiter: per-source one-entry hold registers drained round-robin
// into the single integer register-file write port.
module rv32i_wb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          rf_wen,
  output logic [REG_ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          dup_rd_err
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef logic [DATA_W-1:0] word_t;

  logic [NUM_SRC-1:0]    vld_p0;
  logic [REG_ADDR_W-1:0] rd_p0   [NUM_SRC];
  word_t                 data_p0 [NUM_SRC];

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W-1:0]   winner;
  logic [NUM_SRC-1:0] grant;
  logic               any_grant;
  logic               dup_hit;

  // Round-robin search starts one past the last winner; flush suppresses any grant.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    winner    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + 1 + k) % NUM_SRC);
      if (!flush && !any_grant && vld_p0[scan_idx]) begin
        any_grant = 1'b1;
        winner    = scan_idx;
      end
    end
    if (any_grant) grant[winner] = 1'b1;
  end

  assign src_ready = flush ? '0 : (~vld_p0 | grant);

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = i + 1; j < NUM_SRC; j++) begin
        if (vld_p0[i] && vld_p0[j] && (rd_p0[i] == rd_p0[j]) && (rd_p0[i] != '0))
          dup_hit = 1'b1;
      end
    end
  end

  // Stage p0: hold registers (a draining entry may reload in the same cycle)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p0 <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (flush)
          vld_p0[i] <= 1'b0;
        else if (src_valid[i] && src_ready[i])
          vld_p0[i] <= 1'b1;
        else if (grant[i])
          vld_p0[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        rd_p0[i]   <= src_rd[i*REG_ADDR_W +: REG_ADDR_W];
        data_p0[i] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: registered write port, arbitration pointer and sticky error
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr     <= PTR_W'(NUM_SRC - 1);
      rf_wen     <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      dup_rd_err <= 1'b0;
    end else begin
      rf_wen <= any_grant && (rd_p0[winner] != '0);
      if (any_grant) begin
        rr_ptr   <= winner;
        rf_rd    <= rd_p0[winner];
        rf_wdata <= data_p0[winner];
      end
      if (dup_hit) dup_rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Directed bench for rv32i_wb_arbiter: latency, round-robin order, rd=0 drop,
// fairness, flush, duplicate-rd flag and asynchronous reset.
module tb_rv32i_wb_arbiter;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic [2:0]  src_valid;
  logic [14:0] src_rd;
  logic [95:0] src_data;
  logic [2:0]  src_ready;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        dup_rd_err;

  int n_vec = 0;
  int n_err = 0;

  rv32i_wb_arbiter #(.NUM_SRC(3), .DATA_W(32), .REG_ADDR_W(5)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_rd     (src_rd),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .rf_wen     (rf_wen),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .dup_rd_err (dup_rd_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    src_valid[i]        = v;
    src_rd[i*5 +: 5]    = rd;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    step();
    RST       = 1'b1;
    src_valid = '0;
    flush     = 1'b0;
    #3;
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;
    #1;
    check("rst_wen", rf_wen, 0);
    check("rst_rd", rf_rd, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_dup", dup_rd_err, 0);
    check("rst_ready", src_ready, 3'b111);
    step();
    #3;
    RST = 1'b0;

    // single result: write visible only two edges after the handshake
    set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    src_valid = '0;
    check("t1_wen_n1", rf_wen, 0);
    step();
    check("t1_wen_n2", rf_wen, 1);
    check("t1_rd_n2", rf_rd, 5);
    check("t1_data_n2", rf_wdata, 32'hDEADBEEF);
    step();
    check("t1_wen_n3", rf_wen, 0);

    // three sources held valid: rotation 1,2,3,1,2,3
    do_reset();
    set_src(0, 1'b1, 5'd1, 32'h11);
    set_src(1, 1'b1, 5'd2, 32'h22);
    set_src(2, 1'b1, 5'd3, 32'h33);
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      check("t2_wen", rf_wen, 1);
      check("t2_rd", rf_rd, (k % 3) + 1);
      check("t2_data", rf_wdata, 32'h11 * ((k % 3) + 1));
    end
    src_valid = '0;

    // rd=0 result is accepted and drained without a write
    do_reset();
    set_src(1, 1'b1, 5'd0, 32'h1234);
    #1;
    check("t3_ready", src_ready, 3'b111);
    step();
    src_valid = '0;
    check("t3_wen_a", rf_wen, 0);
    step();
    check("t3_wen_b", rf_wen, 0);
    check("t3_wdata", rf_wdata, 32'h1234);
    step();
    check("t3_wen_c", rf_wen, 0);
    check("t3_ready_after", src_ready, 3'b111);

    // two always-valid sources alternate 0,2,0,2
    do_reset();
    set_src(0, 1'b1, 5'd4, 32'h40);
    set_src(2, 1'b1, 5'd6, 32'h60);
    step();
    check("t4_ready_first", src_ready, 3'b011);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_wen", rf_wen, 1);
      check("t4_rd", rf_rd, (k % 2 == 0) ? 5'd4 : 5'd6);
      check("t4_ready0", src_ready[0], (k % 2 == 1) ? 1'b1 : 1'b0);
    end
    src_valid = '0;

    // flush drops both held entries
    do_reset();
    set_src(0, 1'b1, 5'd8, 32'h80);
    set_src(1, 1'b1, 5'd9, 32'h90);
    step();
    src_valid = '0;
    flush     = 1'b1;
    #1;
    check("t5_ready_flush", src_ready, 3'b000);
    step();
    flush = 1'b0;
    #1;
    check("t5_ready_next", src_ready, 3'b111);
    check("t5_wen_a", rf_wen, 0);
    step();
    check("t5_wen_b", rf_wen, 0);
    step();
    check("t5_wen_c", rf_wen, 0);

    // duplicate rd sets sticky flag; async reset clears everything
    do_reset();
    set_src(0, 1'b1, 5'd7, 32'hA);
    set_src(1, 1'b1, 5'd7, 32'hB);
    step();
    src_valid = '0;
    check("t6_dup_pre", dup_rd_err, 0);
    step();
    check("t6_dup_set", dup_rd_err, 1);
    step();
    step();
    check("t6_dup_sticky", dup_rd_err, 1);
    set_src(2, 1'b1, 5'd10, 32'hCAFE);
    step();
    src_valid = '0;
    step();
    check("t6_wen_before_rst", rf_wen, 1);
    check("t6_rd_before_rst", rf_rd, 10);
    #2;
    RST = 1'b1;
    #1;
    check("t6_rst_wen", rf_wen, 0);
    check("t6_rst_rd", rf_rd, 0);
    check("t6_rst_wdata", rf_wdata, 0);
    check("t6_rst_dup", dup_rd_err, 0);
    check("t6_rst_ready", src_ready, 3'b111);
    RST = 1'b0;
    step();
    check("t6_no_spurious_a", rf_wen, 0);
    step();
    check("t6_no_spurious_b", rf_wen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
